// File: rtl/simon_arb_pkg.sv
// rtl/simon_arb_pkg.sv - shared states, phase lengths and data types for the SIMON round-robin arbiter
package simon_arb_pkg;

    // Default SIMON 32/64 geometry: 16-bit words, four key words
    localparam int SIMON_N = 16;
    localparam int SIMON_M = 4;

    // Length in cycles of the engine start and result-acknowledge strobes
    localparam int ISSUE_CYC = 2;
    localparam int READ_CYC  = 2;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        READ,
        RESP
    } arb_state_e;

    typedef logic [2*SIMON_N-1:0]             block_t;
    typedef logic [SIMON_M-1:0][SIMON_N-1:0]  key_t;

endpackage

// File: rtl/simon_rr_pick.sv
// rtl/simon_rr_pick.sv - combinational round-robin picker starting the search at rr_ptr_i
module simon_rr_pick
    import simon_arb_pkg::*;
#(
    parameter int R  = 2,
    parameter int PW = (R > 1) ? $clog2(R) : 1
) (
    input  logic [R-1:0]  req_valid_i,
    input  logic [PW-1:0] rr_ptr_i,
    output logic [PW-1:0] grant_o,
    output logic          any_valid_o
);

    logic [PW-1:0] idx;

    // Walk the ring from the far end back to rr_ptr_i so the nearest valid line wins
    always_comb begin
        grant_o     = '0;
        any_valid_o = 1'b0;
        idx         = '0;
        for (int k = R - 1; k >= 0; k--) begin
            idx = PW'((int'(rr_ptr_i) + k) % R);
            if (req_valid_i[idx]) begin
                grant_o     = idx;
                any_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/simon_rr_arbiter.sv
// rtl/simon_rr_arbiter.sv - round-robin sequencer sharing one SIMON engine; SIMON_ARB_TIMEOUT_EN adds a WAIT timeout and resp_err
module simon_rr_arbiter
    import simon_arb_pkg::*;
#(
    parameter int N = SIMON_N,
    parameter int M = SIMON_M,
    parameter int R = 2
`ifdef SIMON_ARB_TIMEOUT_EN
    ,
    parameter int TMO = 255
`endif
) (
    input  logic                       clk,
    input  logic                       nR,
    input  logic [R-1:0]               req_valid,
    output logic [R-1:0]               req_ready,
    input  logic [R-1:0][2*N-1:0]      req_plain,
    input  logic [R-1:0][M-1:0][N-1:0] req_key,
    output logic [R-1:0]               resp_valid,
    input  logic [R-1:0]               resp_ready,
    output logic [2*N-1:0]             resp_cipher,
`ifdef SIMON_ARB_TIMEOUT_EN
    output logic                       resp_err,
`endif
    output logic                       busy,
    output logic                       eng_newData,
    output logic                       eng_readData,
    output logic [2*N-1:0]             eng_plain,
    output logic [M-1:0][N-1:0]        eng_key,
    input  logic                       eng_doneData,
    input  logic [2*N-1:0]             eng_cipher
);

    localparam int PW = (R > 1) ? $clog2(R) : 1;

    arb_state_e             state_q, state_d;
    logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]          gid_q, gid_d;
    logic [1:0]             cyc_q, cyc_d;
    logic [R-1:0]           req_ready_q, req_ready_d;
    logic [R-1:0]           resp_valid_q, resp_valid_d;
    logic                   newdata_q, newdata_d;
    logic                   readdata_q, readdata_d;
    logic [2*N-1:0]         plain_q, plain_d;
    logic [M-1:0][N-1:0]    key_q, key_d;
    logic [2*N-1:0]         cipher_q, cipher_d;
    logic                   busy_q, busy_d;
    logic                   go_read;

    logic [PW-1:0]          pick;
    logic                   any_valid;

`ifdef SIMON_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TMO + 1);
    logic [TW-1:0]          wcnt_q, wcnt_d;
    logic                   tmo_q, tmo_d;
    logic                   err_q, err_d;
`endif

    simon_rr_pick #(
        .R  (R),
        .PW (PW)
    ) u_pick (
        .req_valid_i (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (pick),
        .any_valid_o (any_valid)
    );

    // Next-state and next-output logic; every output is the registered copy of its _d
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        gid_d        = gid_q;
        cyc_d        = cyc_q;
        req_ready_d  = '0;
        resp_valid_d = resp_valid_q;
        newdata_d    = 1'b0;
        readdata_d   = 1'b0;
        plain_d      = plain_q;
        key_d        = key_q;
        cipher_d     = cipher_q;
        go_read      = 1'b0;
`ifdef SIMON_ARB_TIMEOUT_EN
        wcnt_d       = wcnt_q;
        tmo_d        = tmo_q;
        err_d        = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    req_ready_d = R'(1) << pick;
                    plain_d     = req_plain[pick];
                    key_d       = req_key[pick];
                    gid_d       = pick;
                    rr_ptr_d    = (pick == PW'(R - 1)) ? '0 : pick + PW'(1);
                    cyc_d       = '0;
                    newdata_d   = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (cyc_q == 2'(ISSUE_CYC - 1)) begin
                    state_d = WAIT;
`ifdef SIMON_ARB_TIMEOUT_EN
                    wcnt_d  = '0;
                    tmo_d   = 1'b0;
`endif
                end else begin
                    cyc_d     = cyc_q + 2'd1;
                    newdata_d = 1'b1;
                end
            end
            WAIT: begin
                if (eng_doneData) begin
                    cipher_d = eng_cipher;
                    go_read  = 1'b1;
                end
`ifdef SIMON_ARB_TIMEOUT_EN
                else if (wcnt_q == TW'(TMO - 1)) begin
                    cipher_d = '0;
                    tmo_d    = 1'b1;
                    go_read  = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + TW'(1);
                end
`endif
                if (go_read) begin
                    readdata_d = 1'b1;
                    cyc_d      = '0;
                    state_d    = READ;
                end
            end
            READ: begin
                if (cyc_q == 2'(READ_CYC - 1)) begin
                    resp_valid_d = R'(1) << gid_q;
                    state_d      = RESP;
`ifdef SIMON_ARB_TIMEOUT_EN
                    err_d        = tmo_q;
`endif
                end else begin
                    cyc_d      = cyc_q + 2'd1;
                    readdata_d = 1'b1;
                end
            end
            RESP: begin
                // Only the granted line's ready completes the handshake
                if (resp_ready[gid_q]) begin
                    resp_valid_d = '0;
                    state_d      = IDLE;
`ifdef SIMON_ARB_TIMEOUT_EN
                    err_d        = 1'b0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset abandons any job in flight
    always_ff @(posedge clk) begin
        if (!nR) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            gid_q        <= '0;
            cyc_q        <= '0;
            req_ready_q  <= '0;
            resp_valid_q <= '0;
            newdata_q    <= 1'b0;
            readdata_q   <= 1'b0;
            plain_q      <= '0;
            key_q        <= '0;
            cipher_q     <= '0;
            busy_q       <= 1'b0;
`ifdef SIMON_ARB_TIMEOUT_EN
            wcnt_q       <= '0;
            tmo_q        <= 1'b0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            gid_q        <= gid_d;
            cyc_q        <= cyc_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            newdata_q    <= newdata_d;
            readdata_q   <= readdata_d;
            plain_q      <= plain_d;
            key_q        <= key_d;
            cipher_q     <= cipher_d;
            busy_q       <= busy_d;
`ifdef SIMON_ARB_TIMEOUT_EN
            wcnt_q       <= wcnt_d;
            tmo_q        <= tmo_d;
            err_q        <= err_d;
`endif
        end
    end

    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_cipher  = cipher_q;
    assign busy         = busy_q;
    assign eng_newData  = newdata_q;
    assign eng_readData = readdata_q;
    assign eng_plain    = plain_q;
    assign eng_key      = key_q;
`ifdef SIMON_ARB_TIMEOUT_EN
    assign resp_err     = err_q;
`endif

endmodule

// File: tb/tb_simon_rr_arbiter.sv
// tb/tb_simon_rr_arbiter.sv - self-checking bench for simon_rr_arbiter with a behavioural SIMON 32/64 engine
module tb_simon_rr_arbiter;

    localparam int R = 2;
    localparam int N = 16;
    localparam int M = 4;
`ifdef SIMON_ARB_TIMEOUT_EN
    localparam int TMO_B = 8;
`endif

    logic                       clk = 1'b0;
    logic                       nR  = 1'b0;
    logic [R-1:0]               req_valid;
    logic [R-1:0]               req_ready;
    logic [R-1:0][2*N-1:0]      req_plain;
    logic [R-1:0][M-1:0][N-1:0] req_key;
    logic [R-1:0]               resp_valid;
    logic [R-1:0]               resp_ready;
    logic [2*N-1:0]             resp_cipher;
    logic                       busy;
    logic                       eng_newData;
    logic                       eng_readData;
    logic [2*N-1:0]             eng_plain;
    logic [M-1:0][N-1:0]        eng_key;
    logic                       eng_doneData;
    logic [2*N-1:0]             eng_cipher;
`ifdef SIMON_ARB_TIMEOUT_EN
    logic                       resp_err;
`endif

    always #5 clk = ~clk;

    simon_rr_arbiter #(
        .N (N),
        .M (M),
        .R (R)
`ifdef SIMON_ARB_TIMEOUT_EN
        ,
        .TMO (TMO_B)
`endif
    ) dut (
        .clk          (clk),
        .nR           (nR),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_plain    (req_plain),
        .req_key      (req_key),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_cipher  (resp_cipher),
`ifdef SIMON_ARB_TIMEOUT_EN
        .resp_err     (resp_err),
`endif
        .busy         (busy),
        .eng_newData  (eng_newData),
        .eng_readData (eng_readData),
        .eng_plain    (eng_plain),
        .eng_key      (eng_key),
        .eng_doneData (eng_doneData),
        .eng_cipher   (eng_cipher)
    );

    int          n_checks = 0;
    int          n_fails  = 0;
    int          cyc      = 0;
    int          nd_run = 0, nd_len = 0, nd_start = 0, nd_rises = 0;
    int          rd_run = 0, rd_len = 0, rd_start = 0;
    int          ref_ptr  = 0;
    int          eng_lat  = 1;
    int          last_grant = -1;
    logic [31:0] last_cipher = '0;
    int          g_order [4];

    // SIMON 32/64 straight from the cipher definition
    function automatic logic [31:0] simon32(input logic [31:0] pt, input logic [3:0][15:0] key);
        logic [15:0] k [32];
        logic [61:0] z;
        logic [15:0] x, y, t;
        z = 62'b11111010001001010110000111001101111101000100101011000011100110;
        for (int i = 0; i < 4; i++) k[i] = key[i];
        for (int i = 4; i < 32; i++) begin
            t = {k[i-1][2:0], k[i-1][15:3]} ^ k[i-3];
            t = t ^ {t[0], t[15:1]};
            k[i] = ~k[i-4] ^ t ^ {15'b0, z[61 - ((i - 4) % 62)]} ^ 16'd3;
        end
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < 32; i++) begin
            t = x;
            x = y ^ ({x[14:0], x[15]} & {x[7:0], x[15:8]}) ^ {x[13:0], x[15:14]} ^ k[i];
            y = t;
        end
        return {x, y};
    endfunction

    // First valid requester searching from ptr around the ring
    function automatic int ref_pick(input logic [R-1:0] mask, input int ptr);
        for (int k = 0; k < R; k++) begin
            if (mask[(ptr + k) % R]) return (ptr + k) % R;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < R; i++) begin
            req_plain[i] = $urandom();
            req_key[i]   = {$urandom(), $urandom()};
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".req_ready"}, req_ready, 0);
        chk({tag, ".resp_valid"}, resp_valid, 0);
        chk({tag, ".newData"}, eng_newData, 0);
        chk({tag, ".readData"}, eng_readData, 0);
        chk({tag, ".eng_plain"}, eng_plain, 0);
        chk({tag, ".eng_key"}, eng_key, 0);
        chk({tag, ".resp_cipher"}, resp_cipher, 0);
        chk({tag, ".busy"}, busy, 0);
    endtask

    // One complete job: request, grant, engine exchange, response with optional stall
    task automatic run_job(input logic [R-1:0] mask, input int lat, input int rdly, input string tag);
        int          exp_g, waited, bad, wc, rises0;
        logic [R-1:0] exp_oh;
        logic [31:0] exp_c, held_c;
        logic        exp_err;
        exp_g   = ref_pick(mask, ref_ptr);
        ref_ptr = (exp_g + 1) % R;
        exp_oh  = R'(1) << exp_g;
        exp_c   = simon32(req_plain[exp_g], req_key[exp_g]);
        exp_err = 1'b0;
        wc      = (lat - 1 > 1) ? lat - 1 : 1;
`ifdef SIMON_ARB_TIMEOUT_EN
        if (wc > TMO_B) begin
            wc      = TMO_B;
            exp_err = 1'b1;
            exp_c   = '0;
        end
`endif
        eng_lat   = lat;
        req_valid = mask;
        waited    = 0;
        do begin
            tick();
            waited++;
        end while (req_ready == '0 && waited < 50);
        for (int i = 0; i < R; i++) if (req_ready[i]) last_grant = i;
        chk({tag, ".grant"}, req_ready, exp_oh);
        chk({tag, ".eng_plain"}, eng_plain, req_plain[exp_g]);
        chk({tag, ".eng_key"}, eng_key, req_key[exp_g]);
        req_valid = '0;
        tick();
        chk({tag, ".ready_pulse"}, req_ready, 0);
        waited = 0;
        while (resp_valid == '0 && waited < 400) begin
            tick();
            waited++;
        end
        last_cipher = resp_cipher;
        chk({tag, ".resp_valid"}, resp_valid, exp_oh);
        chk({tag, ".cipher"}, resp_cipher, exp_c);
        chk({tag, ".newData_len"}, nd_len, 2);
        chk({tag, ".readData_len"}, rd_len, 2);
        chk({tag, ".issue_to_read"}, rd_start - nd_start, 2 + wc);
        chk({tag, ".read_to_resp"}, cyc - rd_start, 2);
`ifdef SIMON_ARB_TIMEOUT_EN
        chk({tag, ".resp_err"}, resp_err, exp_err);
`endif
        held_c     = resp_cipher;
        rises0     = nd_rises;
        bad        = 0;
        resp_ready = ~exp_oh;
        req_valid  = '1;
        repeat (rdly) begin
            tick();
            if (resp_valid !== exp_oh || resp_cipher !== held_c || req_ready !== '0 || busy !== 1'b1) bad++;
        end
        chk({tag, ".stall_stable"}, bad, 0);
        chk({tag, ".stall_no_issue"}, nd_rises - rises0, 0);
        resp_ready = exp_oh;
        req_valid  = '0;
        tick();
        resp_ready = '0;
        chk({tag, ".resp_clear"}, resp_valid, 0);
        chk({tag, ".idle"}, busy, 0);
        chk({tag, ".cipher_held"}, resp_cipher, held_c);
    endtask

    // Engine model: done is a level that rises lat cycles after the first start cycle
    initial begin : engine
        int          e_cnt;
        bit          e_active;
        logic [31:0] e_res;
        e_cnt        = 0;
        e_active     = 0;
        e_res        = '0;
        eng_doneData = 1'b0;
        eng_cipher   = '0;
        forever begin
            @(negedge clk);
            if (!nR || eng_readData) begin
                e_active     = 0;
                eng_doneData = 1'b0;
            end else if (!e_active && eng_newData) begin
                e_active = 1;
                e_cnt    = eng_lat;
                e_res    = simon32(eng_plain, eng_key);
                if (e_cnt <= 0) eng_doneData = 1'b1;
            end else if (e_active && !eng_doneData) begin
                e_cnt--;
                if (e_cnt <= 0) eng_doneData = 1'b1;
            end
            eng_cipher = eng_doneData ? e_res : $urandom();
        end
    end

    // Strobe run-length recorder
    initial begin : monitor
        forever begin
            @(negedge clk);
            cyc++;
            if (eng_newData) begin
                if (nd_run == 0) begin
                    nd_start = cyc;
                    nd_rises++;
                end
                nd_run++;
            end else if (nd_run != 0) begin
                nd_len = nd_run;
                nd_run = 0;
            end
            if (eng_readData) begin
                if (rd_run == 0) rd_start = cyc;
                rd_run++;
            end else if (rd_run != 0) begin
                rd_len = rd_run;
                rd_run = 0;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int waited;
        req_valid  = '0;
        resp_ready = '0;
        req_plain  = '0;
        req_key    = '0;
        nR         = 1'b0;
        repeat (3) tick();
        check_zero("reset");
        nR = 1'b1;
        tick();

        for (int j = 0; j < 4; j++) begin
            rand_data();
            run_job(2'b11, $urandom_range(1, 5), 0, $sformatf("cont%0d", j));
            g_order[j] = last_grant;
        end
        chk("cont.order0", g_order[0], 0);
        chk("cont.order1", g_order[1], 1);
        chk("cont.order2", g_order[2], 0);
        chk("cont.order3", g_order[3], 1);

        req_plain[0] = 32'h65656877;
        req_key[0]   = 64'h1918111009080100;
        run_job(2'b01, 4, 0, "kat");
        chk("kat.vector", last_cipher, 32'hC69BE9BB);

        rand_data();
        run_job(2'b10, 3, 10, "backpressure");

        rand_data();
        run_job(2'b01, 0, 1, "early_done");

        rand_data();
        eng_lat   = 1000;
        req_valid = 2'b01;
        waited    = 0;
        do begin
            tick();
            waited++;
        end while (req_ready == '0 && waited < 50);
        chk("rstwait.grant", req_ready, 2'b01);
        ref_ptr   = 1;
        req_valid = '0;
        waited    = 0;
        while (!eng_newData && waited < 10) begin
            tick();
            waited++;
        end
        while (eng_newData && waited < 20) begin
            tick();
            waited++;
        end
        tick();
        chk("rstwait.busy", busy, 1);
        nR = 1'b0;
        tick();
        nR = 1'b1;
        check_zero("rstwait");
        ref_ptr = 0;
        rand_data();
        run_job(2'b11, 2, 0, "after_rst_both");
        rand_data();
        run_job(2'b10, 2, 0, "after_rst_req1");

        for (int j = 0; j < 12; j++) begin
            rand_data();
            run_job(R'($urandom_range(1, (1 << R) - 1)), $urandom_range(0, 6),
                    $urandom_range(0, 4), $sformatf("rand%0d", j));
        end

`ifdef SIMON_ARB_TIMEOUT_EN
        rand_data();
        run_job(2'b01, 1000, 2, "timeout");
        rand_data();
        run_job(2'b01, 3, 0, "after_timeout");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
